cache_arbiter: RTL and testbench

//  Shares the single physical-memory port between the instruction cache (read-only) and the data cache (read/write).

---
 rtl/rv32i_types.sv | 13 +
 rtl/cache_arbiter.sv | 117 +++++++++++
 tb/tb_cache_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I memory-hierarchy types: cache line width and arbiter states.
package rv32i_types;

    // Cache line width shared by the icache, dcache and the memory arbiter.
    localparam int unsigned CACHE_LINE_W = 256;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates the single physical-memory port between the split L1 caches.
// One line transaction at a time; dcache has priority, but icache is granted
// after MAX_D_BURST consecutive dcache grants taken while it was waiting.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LINE_W      = CACHE_LINE_W,
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp
);

    localparam int unsigned   SW         = $clog2(MAX_D_BURST + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_BURST);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] d_streak_q, d_streak_d;
    logic          d_req;
    logic          i_starved;

    assign d_req     = d_read | d_write;
    assign i_starved = i_read && (d_streak_q == STREAK_MAX);

    // Read data is a straight pass-through; only meaningful alongside the resp.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // State and dcache-streak registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            d_streak_q <= '0;
        end else begin
            state_q    <= state_d;
            d_streak_q <= d_streak_d;
        end
    end

    // Grant decision in IDLE; memory port steering and resp routing per grant.
    always_comb begin
        state_d    = state_q;
        d_streak_d = d_streak_q;
        m_read     = 1'b0;
        m_write    = 1'b0;
        m_address  = '0;
        m_wdata    = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (d_req && !i_starved) begin
                    state_d = ARB_SERVE_D;
                    if (!i_read) begin
                        d_streak_d = '0;
                    end else if (d_streak_q != STREAK_MAX) begin
                        d_streak_d = d_streak_q + SW'(1);
                    end
                end else if (i_read) begin
                    state_d    = ARB_SERVE_I;
                    d_streak_d = '0;
                end
            end
            ARB_SERVE_I: begin
                m_read    = 1'b1;
                m_address = i_address;
                i_resp    = m_resp;
                if (m_resp) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_SERVE_D: begin
                m_read    = d_read;
                m_write   = d_write;
                m_address = d_address;
                m_wdata   = d_wdata;
                d_resp    = m_resp;
                if (m_resp) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Requester protocol checks; no recovery logic exists for these cases.
    a_no_read_and_write: assert property (@(posedge clk) disable iff (rst)
        !(d_read && d_write));
    a_i_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == ARB_SERVE_I) |-> i_read);
    a_d_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == ARB_SERVE_D) |-> (d_read || d_write));
    a_i_stable: assert property (@(posedge clk) disable iff (rst)
        (state_q == ARB_SERVE_I && $past(state_q) == ARB_SERVE_I) |-> $stable(i_address));
    a_d_stable: assert property (@(posedge clk) disable iff (rst)
        (state_q == ARB_SERVE_D && $past(state_q) == ARB_SERVE_D)
            |-> ($stable(d_address) && $stable(d_wdata)));

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed scenarios followed by random
// icache/dcache traffic against a latency-randomised memory model.
module tb_cache_arbiter;
    import rv32i_types::*;

    localparam int unsigned AW   = 32;
    localparam int unsigned LW   = CACHE_LINE_W;
    localparam int unsigned MAXB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, i_resp, d_read, d_write, d_resp;
    logic          m_read, m_write, m_resp;
    logic [AW-1:0] i_address, d_address, m_address;
    logic [LW-1:0] i_rdata, d_wdata, d_rdata, m_wdata, m_rdata;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } exp_t;

    exp_t          i_q[$];
    exp_t          d_q[$];
    logic [LW-1:0] dshadow[logic [AW-1:0]];
    logic [LW-1:0] mem[logic [AW-1:0]];

    int n_pass    = 0;
    int n_total   = 0;
    int mem_lat   = -1;
    int spur_req  = 0;
    int spur_done = 0;

    cache_arbiter #(
        .ADDR_W      (AW),
        .LINE_W      (LW),
        .MAX_D_BURST (MAXB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_address (i_address),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_address (d_address),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .m_read    (m_read),
        .m_write   (m_write),
        .m_address (m_address),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_resp    (m_resp)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] pattern(input logic [AW-1:0] a);
        return {8{a ^ 32'hC0FF_EE00}};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    function void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic i_issue(input logic [AW-1:0] a);
        i_address = a;
        i_read    = 1'b1;
        i_q.push_back('{1'b0, a, pattern(a)});
    endtask

    task automatic d_issue(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] data);
        d_read    = !wr;
        d_write   = wr;
        d_address = a;
        d_wdata   = data;
        if (wr) begin
            dshadow[a] = data;
            d_q.push_back('{1'b1, a, data});
        end else begin
            d_q.push_back('{1'b0, a, dshadow.exists(a) ? dshadow[a] : pattern(a)});
        end
    endtask

    task automatic wait_resp(output bit gi, output bit gd);
        gi = 1'b0;
        gd = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (i_resp || d_resp) begin
                gi = i_resp;
                gd = d_resp;
                return;
            end
        end
        n_total++;
        $display("FAIL resp_timeout: got no response expected one within 300 cycles");
    endtask

    task automatic wait_sig(input bit want_i);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (want_i ? i_resp : d_resp) return;
        end
        n_total++;
        $display("FAIL %s_resp_timeout: got no response expected one within 300 cycles",
                 want_i ? "i" : "d");
    endtask

    task automatic icache_agent(input int n);
        for (int t = 0; t < n; t++) begin
            i_issue({4'h0, 23'($urandom), 5'b0});
            wait_sig(1'b1);
            step();
            i_read = 1'b0;
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    task automatic dcache_agent(input int n);
        for (int t = 0; t < n; t++) begin
            d_issue(1'($urandom_range(0, 1)), {4'h1, 20'h0, 3'($urandom), 5'b0}, rand_line());
            wait_sig(1'b0);
            step();
            d_read  = 1'b0;
            d_write = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    // Memory model: random (or forced) latency, writes land on completion.
    initial begin
        int cnt;
        bit active;
        m_resp  = 1'b0;
        m_rdata = '0;
        active  = 1'b0;
        cnt     = 0;
        forever begin
            step();
            if (rst) begin
                active = 1'b0;
                m_resp = 1'b0;
            end else if (m_resp) begin
                m_resp = 1'b0;
            end else if (spur_done != spur_req) begin
                if (!(m_read || m_write)) begin
                    m_resp  = 1'b1;
                    m_rdata = rand_line();
                    spur_done++;
                end
            end else if (m_read || m_write) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 4));
                end
                if (cnt == 0) begin
                    active = 1'b0;
                    m_resp = 1'b1;
                    if (m_write) begin
                        mem[m_address] = m_wdata;
                        m_rdata        = rand_line();
                    end else begin
                        m_rdata = mem.exists(m_address) ? mem[m_address] : pattern(m_address);
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: predicts grants from the priority/starvation rule and checks
    // strobes, resp routing and returned data against the scoreboard queues.
    initial begin
        bit   ps, pr, pi, pd, strobe, exp_ir, exp_dr;
        int   k, cur, exp_g, act_g;
        exp_t e;
        ps = 0; pr = 0; pi = 0; pd = 0; k = 0; cur = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs", {m_read, m_write, i_resp, d_resp}, 4'b0);
                ps = 0; pr = 0; pi = 0; pd = 0; k = 0; cur = 0;
                continue;
            end
            strobe = m_read | m_write;
            if (!ps && (pi || pd)) chk("grant_latency", strobe, 1);
            if (pr) chk("idle_bubble", strobe, 0);
            if (!ps && strobe) begin
                exp_g = (pd && !(pi && k == MAXB)) ? 2 : 1;
                act_g = (m_write || m_address[31:28] != 4'h0) ? 2 : 1;
                chk("grant_select", act_g, exp_g);
                if (exp_g == 2) k = pi ? ((k == MAXB) ? k : k + 1) : 0;
                else k = 0;
                cur = exp_g;
            end
            if (cur != 0) chk("grant_hold", strobe, 1);
            if (cur == 1 && strobe) begin
                chk("strobe_I_ctl", {m_read, m_write, m_address}, {2'b10, i_address});
                chk("strobe_I_wdata", m_wdata, '0);
            end
            if (cur == 2 && strobe) begin
                chk("strobe_D_ctl", {m_read, m_write, m_address}, {d_read, d_write, d_address});
                chk("strobe_D_wdata", m_wdata, d_wdata);
            end
            exp_ir = m_resp && cur == 1;
            exp_dr = m_resp && cur == 2;
            if (m_resp || i_resp || d_resp) chk("resp_route", {i_resp, d_resp}, {exp_ir, exp_dr});
            if (exp_ir) begin
                chk("i_sb_occupancy", i_q.size() != 0, 1);
                if (i_q.size() != 0) begin
                    e = i_q.pop_front();
                    chk("i_rdata", i_rdata, e.data);
                    chk("i_addr", m_address, e.addr);
                end
            end
            if (exp_dr) begin
                chk("d_sb_occupancy", d_q.size() != 0, 1);
                if (d_q.size() != 0) begin
                    e = d_q.pop_front();
                    chk("d_addr", m_address, e.addr);
                    chk("d_op", m_write, e.wr);
                    if (e.wr) chk("d_wdata", m_wdata, e.data);
                    else chk("d_rdata", d_rdata, e.data);
                end
            end
            pr = exp_ir || exp_dr;
            if (pr) cur = 0;
            ps = strobe;
            pi = i_read;
            pd = d_read | d_write;
        end
    end

    // Directed scenarios, then concurrent random traffic, then summary.
    initial begin
        bit gi, gd;
        int nd;
        bit got_i;
        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Reset in the middle of a dcache writeback.
        mem_lat = 10;
        d_write = 1'b1; d_address = 32'h1000_0040; d_wdata = rand_line();
        repeat (3) step();
        chk("pre_rst_mwrite", m_write, 1);
        rst = 1'b1;
        #1 chk("rst_mwrite", m_write, 0);
        step();
        d_write = 1'b0;
        step();
        rst = 1'b0;
        repeat (3) step();

        // Lone icache read, memory answers 5 cycles after the strobe.
        mem_lat = 5;
        i_issue(32'h0000_0060);
        wait_resp(gi, gd);
        chk("t2_i_only", {gi, gd}, 2'b10);
        step(); i_read = 1'b0;
        step();
        mem_lat = -1;

        // Simultaneous requests: dcache first, then icache after a bubble.
        i_issue(32'h0000_0080);
        d_issue(1'b1, 32'h1000_1000, rand_line());
        wait_resp(gi, gd);
        chk("t3_d_first", {gi, gd}, 2'b01);
        step(); d_write = 1'b0;
        wait_resp(gi, gd);
        chk("t3_i_second", {gi, gd}, 2'b10);
        step(); i_read = 1'b0;
        step();

        // Starvation guard: dcache re-requests every cycle while icache waits.
        i_issue(32'h0000_0100);
        d_issue(1'b0, 32'h1000_0000, '0);
        nd = 0; got_i = 0;
        for (int it = 0; it < 10 && !got_i; it++) begin
            wait_resp(gi, gd);
            if (gi) got_i = 1'b1;
            else if (gd) begin
                nd++;
                step();
                d_issue(1'b0, 32'h1000_0000 + 32'((it + 1) * 32), '0);
            end else break;
        end
        chk("t4_dgrants_before_i", nd, MAXB);
        step(); i_read = 1'b0;
        wait_resp(gi, gd);
        chk("t4_d_after_i", {gi, gd}, 2'b01);
        step(); d_read = 1'b0;
        step();

        // Spurious m_resp while idle, then a normal dcache read.
        @(negedge clk);
        spur_req++;
        step();
        @(negedge clk);
        chk("t5_spurious", {m_resp, i_resp, d_resp}, 3'b100);
        step();
        d_issue(1'b0, 32'h1000_1000, '0);
        wait_resp(gi, gd);
        chk("t5_d_after_spur", {gi, gd}, 2'b01);
        step(); d_read = 1'b0;
        step();

        // Back-to-back dcache read then write, then read back.
        d_issue(1'b0, 32'h1000_0020, '0);
        wait_resp(gi, gd);
        chk("t6_read", {gi, gd}, 2'b01);
        step();
        d_issue(1'b1, 32'h1000_0020, rand_line());
        wait_resp(gi, gd);
        chk("t6_write", {gi, gd}, 2'b01);
        step();
        d_issue(1'b0, 32'h1000_0020, '0);
        wait_resp(gi, gd);
        chk("t6_readback", {gi, gd}, 2'b01);
        step(); d_read = 1'b0;
        step();

        // Random concurrent traffic.
        fork
            icache_agent(40);
            dcache_agent(60);
        join
        repeat (10) step();
        chk("i_q_drained", i_q.size(), 0);
        chk("d_q_drained", d_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
